// File: rtl/wb_arb_pkg.sv
// Shared constants for the WISHBONE master arbiter: FSM encodings, bus widths,
// idle (reset) values of the slave-side bus and a one-hot to index helper.
package wb_arb_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam int MAX_MASTERS = 4;
    localparam int IDX_W       = 2;

    localparam logic [WB_ADR_W-1:0] ADR_RST = '0;
    localparam logic [WB_DAT_W-1:0] DAT_RST = '0;
    localparam logic [WB_SEL_W-1:0] SEL_RST = '0;

    function automatic logic [IDX_W-1:0] oh_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Rotating-priority selector: the first requester found searching upward from
// last_i+1 (modulo NUM_MASTERS) wins.
module wb_rr_select
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic [NUM_MASTERS-1:0] win_o,
    output logic                   valid_o
);

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        // k is the distance from the previous winner; the smallest distance wins.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!valid_o && req_i[j] && (j == (int'(last_i) + k) % NUM_MASTERS)) begin
                    win_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin WISHBONE arbiter: NUM_MASTERS masters share one slave-side bus.
// Optional ACK watchdog built only when WB_ARB_TIMEOUT_EN is defined.
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 256
) (
    input  logic                            CLK_I,
    input  logic                            reset_n,
    input  logic [NUM_MASTERS-1:0]          m_CYC_I,
    input  logic [NUM_MASTERS-1:0]          m_STB_I,
    input  logic [NUM_MASTERS-1:0]          m_WE_I,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_ADR_I,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_SEL_I,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_DAT_I,
    output logic [WB_DAT_W-1:0]             m_DAT_O,
    output logic [NUM_MASTERS-1:0]          m_ACK_O,
    output logic [NUM_MASTERS-1:0]          m_ERR_O,
    output logic                            CYC_O,
    output logic                            STB_O,
    output logic                            WE_O,
    output logic [WB_ADR_W-1:0]             ADR_O,
    output logic [WB_SEL_W-1:0]             SEL_O,
    output logic [WB_DAT_W-1:0]             slave_DAT_O,
    input  logic [WB_DAT_W-1:0]             slave_DAT_I,
    input  logic                            ACK_I,
    output logic [NUM_MASTERS-1:0]          grant_o
);

    // Handshake: CYC held high owns the bus for the whole cycle; a beat
    // completes on a cycle where STB_O and ACK_I are both high.
    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;

    logic [NUM_MASTERS-1:0] rr_win;
    logic                   rr_valid;

    logic                cyc_mux, stb_mux, we_mux;
    logic [WB_ADR_W-1:0] adr_mux;
    logic [WB_SEL_W-1:0] sel_mux;
    logic [WB_DAT_W-1:0] dat_mux;
    logic                wd_fire;

    wb_rr_select #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rr_select (
        .req_i  (m_CYC_I),
        .last_i (last_grant_q),
        .win_o  (rr_win),
        .valid_o(rr_valid)
    );

    // With grant_q all zero nothing is selected, so the bus idles at zero.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = ADR_RST;
        sel_mux = SEL_RST;
        dat_mux = DAT_RST;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                cyc_mux = m_CYC_I[i];
                stb_mux = m_STB_I[i];
                we_mux  = m_WE_I[i];
                adr_mux = m_ADR_I[WB_ADR_W*i +: WB_ADR_W];
                sel_mux = m_SEL_I[WB_SEL_W*i +: WB_SEL_W];
                dat_mux = m_DAT_I[WB_DAT_W*i +: WB_DAT_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if (state_q == S_IDLE) begin
            if (rr_valid) begin
                grant_d = rr_win;
                state_d = S_GRANT;
            end
        end else if (!cyc_mux) begin
            last_grant_d = oh_to_idx(MAX_MASTERS'(grant_q));
            grant_d      = '0;
            state_d      = S_IDLE;
        end
    end

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    // The firing cycle forces STB_O low, so the count restarts from zero.
    always_comb begin
        wd_fire  = (state_q == S_GRANT) && stb_mux && !ACK_I &&
                   (wd_cnt_q == WD_W'(TIMEOUT - 1));
        wd_cnt_d = '0;
        if ((state_q == S_GRANT) && cyc_mux && stb_mux && !ACK_I && !wd_fire) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_I or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign m_ERR_O = wd_fire ? grant_q : '0;
`else
    assign wd_fire = 1'b0;
    assign m_ERR_O = '0;
`endif

    assign CYC_O       = cyc_mux & ~wd_fire;
    assign STB_O       = stb_mux & ~wd_fire;
    assign WE_O        = we_mux;
    assign ADR_O       = adr_mux;
    assign SEL_O       = sel_mux;
    assign slave_DAT_O = dat_mux;
    assign m_ACK_O     = ACK_I ? grant_q : '0;
    assign m_DAT_O     = slave_DAT_I;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: directed scenarios plus random traffic, all
// checked every cycle against an owner/last-owner model of the arbitration rules.
module tb_wb_master_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic            CLK_I = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    m_CYC_I = '0, m_STB_I = '0, m_WE_I = '0;
    logic [30*N-1:0] m_ADR_I = '0;
    logic [4*N-1:0]  m_SEL_I = '0;
    logic [32*N-1:0] m_DAT_I = '0;
    logic [31:0]     m_DAT_O;
    logic [N-1:0]    m_ACK_O, m_ERR_O, grant_o;
    logic            CYC_O, STB_O, WE_O;
    logic [29:0]     ADR_O;
    logic [3:0]      SEL_O;
    logic [31:0]     slave_DAT_O;
    logic [31:0]     slave_DAT_I = '0;
    logic            ACK_I = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: current owner (-1 = bus free), previous owner, wait count
    int owner = -1;
    int last  = N - 1;
    int wd    = 0;

    wb_master_arbiter #(
        .NUM_MASTERS(N),
        .TIMEOUT    (TO)
    ) dut (
        .CLK_I      (CLK_I),
        .reset_n    (reset_n),
        .m_CYC_I    (m_CYC_I),
        .m_STB_I    (m_STB_I),
        .m_WE_I     (m_WE_I),
        .m_ADR_I    (m_ADR_I),
        .m_SEL_I    (m_SEL_I),
        .m_DAT_I    (m_DAT_I),
        .m_DAT_O    (m_DAT_O),
        .m_ACK_O    (m_ACK_O),
        .m_ERR_O    (m_ERR_O),
        .CYC_O      (CYC_O),
        .STB_O      (STB_O),
        .WE_O       (WE_O),
        .ADR_O      (ADR_O),
        .SEL_O      (SEL_O),
        .slave_DAT_O(slave_DAT_O),
        .slave_DAT_I(slave_DAT_I),
        .ACK_I      (ACK_I),
        .grant_o    (grant_o)
    );

    // clock / reset
    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic clear_inputs;
        m_CYC_I = '0;
        m_STB_I = '0;
        m_WE_I  = '0;
        ACK_I   = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick;
        clear_inputs;
        tick;
        reset_n = 1'b1;
    endtask

    // model compare: outputs are settled at the falling edge
    always @(negedge CLK_I) begin
        logic         e_cyc, e_stb, e_we, fire;
        logic [29:0]  e_adr;
        logic [3:0]   e_sel;
        logic [31:0]  e_dat;
        logic [N-1:0] e_ack, e_err, e_grant;
        int           cand;
        if (!reset_n) begin
            owner = -1;
            last  = N - 1;
            wd    = 0;
        end
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; fire = 1'b0;
        e_adr = '0; e_sel = '0; e_dat = '0;
        e_ack = '0; e_err = '0; e_grant = '0;
        if (owner >= 0) begin
            e_cyc   = m_CYC_I[owner];
            e_stb   = m_STB_I[owner];
            e_we    = m_WE_I[owner];
            e_adr   = m_ADR_I[30*owner +: 30];
            e_sel   = m_SEL_I[4*owner +: 4];
            e_dat   = m_DAT_I[32*owner +: 32];
            e_grant = N'(1) << owner;
            e_ack   = ACK_I ? e_grant : '0;
`ifdef WB_ARB_TIMEOUT_EN
            fire = (wd == TO - 1) && m_STB_I[owner] && !ACK_I;
`endif
            if (fire) begin
                e_err = e_grant;
                e_cyc = 1'b0;
                e_stb = 1'b0;
            end
        end
        check("model_grant", grant_o, e_grant);
        check("model_cyc", CYC_O, e_cyc);
        check("model_stb", STB_O, e_stb);
        check("model_we", WE_O, e_we);
        check("model_adr", ADR_O, e_adr);
        check("model_sel", SEL_O, e_sel);
        check("model_wdat", slave_DAT_O, e_dat);
        check("model_ack", m_ACK_O, e_ack);
        check("model_err", m_ERR_O, e_err);
        check("model_rdat", m_DAT_O, slave_DAT_I);
        if (reset_n) begin
            if (owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    cand = (last + k) % N;
                    if (owner < 0 && m_CYC_I[cand]) owner = cand;
                end
                wd = 0;
            end else if (!m_CYC_I[owner]) begin
                last  = owner;
                owner = -1;
                wd    = 0;
            end else if (m_STB_I[owner] && !ACK_I && !fire) begin
                wd++;
            end else begin
                wd = 0;
            end
        end
    end

    initial begin
        int            order[6];
        int            n_ord;
        logic [N-1:0]  prev, acked;

        // reset state
        #1;
        check("rst_grant", grant_o, 3'b000);
        check("rst_cyc", CYC_O, 1'b0);
        check("rst_ack", m_ACK_O, 3'b000);
        tick;
        tick;
        reset_n = 1'b1;

        // single master read, slave acks two cycles after STB
        m_CYC_I[1] = 1'b1; m_STB_I[1] = 1'b1; m_WE_I[1] = 1'b0;
        m_ADR_I[30 +: 30] = 30'h4;
        tick;
        check("single_grant", grant_o, 3'b010);
        check("single_adr", ADR_O, 30'h4);
        check("single_stb", STB_O, 1'b1);
        check("single_ack_early", m_ACK_O, 3'b000);
        tick;
        check("single_ack_wait", m_ACK_O, 3'b000);
        tick;
        ACK_I = 1'b1; slave_DAT_I = 32'hCAFE_0001;
        #1;
        check("single_ack", m_ACK_O, 3'b010);
        check("single_rdat", m_DAT_O, 32'hCAFE_0001);
        tick;
        ACK_I = 1'b0; m_CYC_I[1] = 1'b0; m_STB_I[1] = 1'b0;
        #1;
        check("single_ack_once", m_ACK_O, 3'b000);
        check("single_cyc_drop", CYC_O, 1'b0);
        tick;
        check("single_release", grant_o, 3'b000);

        // a CYC pulse that is gone by the arbitration edge wins nothing
        m_CYC_I[2] = 1'b1;
        #2;
        m_CYC_I[2] = 1'b0;
        tick;
        check("late_cyc_no_grant", grant_o, 3'b000);

        // simultaneous requests right after reset
        do_reset;
        m_CYC_I = 3'b101; m_STB_I = 3'b101;
        tick;
        check("simul_first", grant_o, 3'b001);
        ACK_I = 1'b1;
        #1;
        check("simul_ack0", m_ACK_O, 3'b001);
        tick;
        ACK_I = 1'b0; m_CYC_I[0] = 1'b0; m_STB_I[0] = 1'b0;
        tick;
        check("simul_dead_cycle", grant_o, 3'b000);
        tick;
        check("simul_second", grant_o, 3'b100);
        m_CYC_I[2] = 1'b0; ACK_I = 1'b1;
        #1;
        check("drop_with_ack", m_ACK_O, 3'b100);
        check("drop_with_ack_cyc", CYC_O, 1'b0);
        tick;
        ACK_I = 1'b0; m_STB_I = '0;
        tick;
        check("simul_release", grant_o, 3'b000);

        // fairness: all masters request continuously, single-beat cycles
        do_reset;
        n_ord = 0;
        prev  = '0;
        acked = '0;
        m_CYC_I = '1; m_STB_I = '1;
        for (int c = 0; c < 60 && n_ord < 6; c++) begin
            tick;
            for (int i = 0; i < N; i++) begin
                m_CYC_I[i] = !acked[i];
                m_STB_I[i] = !acked[i];
            end
            acked = '0;
            #1;
            if (grant_o != '0 && grant_o != prev) begin
                for (int i = 0; i < N; i++) if (grant_o[i]) order[n_ord] = i;
                n_ord++;
            end
            prev  = grant_o;
            ACK_I = STB_O;
            #1;
            acked = m_ACK_O;
        end
        check("fair_count", n_ord, 6);
        for (int i = 0; i < n_ord; i++) check("fair_order", order[i], i % 3);
        clear_inputs;
        tick;
        tick;
        check("fair_idle", grant_o, 3'b000);

        // lock: master 2 runs 4 beats while master 0 waits
        m_CYC_I[2] = 1'b1;
        tick;
        check("lock_grant", grant_o, 3'b100);
        m_CYC_I[0] = 1'b1; m_STB_I[0] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            m_STB_I[2] = 1'b1;
            tick;
            check("lock_hold", grant_o, 3'b100);
            ACK_I = 1'b1;
            #1;
            check("lock_ack", m_ACK_O, 3'b100);
            tick;
            ACK_I = 1'b0; m_STB_I[2] = 1'b0;
            check("lock_hold2", grant_o, 3'b100);
        end
        m_CYC_I[2] = 1'b0;
        tick;
        check("lock_release", grant_o, 3'b000);
        tick;
        check("lock_next", grant_o, 3'b001);
        clear_inputs;
        tick;
        tick;

        // reset in the middle of a transaction
        m_CYC_I[1] = 1'b1; m_STB_I[1] = 1'b1;
        tick;
        check("mid_cyc", CYC_O, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cyc", CYC_O, 1'b0);
        check("mid_rst_stb", STB_O, 1'b0);
        check("mid_rst_grant", grant_o, 3'b000);
        clear_inputs;
        tick;
        tick;
        reset_n = 1'b1;
        m_CYC_I = 3'b011; m_STB_I = 3'b011;
        tick;
        check("mid_prio0", grant_o, 3'b001);
        clear_inputs;
        tick;
        tick;

        // watchdog: slave never answers
        m_CYC_I[0] = 1'b1; m_STB_I[0] = 1'b1;
        tick;
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 17; k++) begin
            check("wd_err", m_ERR_O, (k == TO) ? 3'b001 : 3'b000);
            check("wd_cyc", CYC_O, (k == TO) ? 1'b0 : 1'b1);
            tick;
        end
`else
        for (int k = 1; k <= 20; k++) begin
            check("wd_off_err", m_ERR_O, 3'b000);
            tick;
        end
`endif
        clear_inputs;
        tick;
        tick;

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) m_CYC_I[i] = ~m_CYC_I[i];
                m_ADR_I[30*i +: 30] = 30'($urandom);
                m_SEL_I[4*i +: 4]   = 4'($urandom);
                m_DAT_I[32*i +: 32] = $urandom;
            end
            m_STB_I     = N'($urandom);
            m_WE_I      = N'($urandom);
            ACK_I       = ($urandom_range(0, 2) == 0);
            slave_DAT_I = $urandom;
            if (c == 700) begin
                #2;
                reset_n = 1'b0;
                tick;
                reset_n = 1'b1;
            end else begin
                tick;
            end
        end
        clear_inputs;
        tick;
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
